timer_gen: RTL and testbench

- Parametrised successor to the free-running carry timer.
- Cyclic counter between REL and CYCLE-1 with:
  - up or down direction
  - auto-reload or one-shot mode
  - runtime load
  - cascade tick input (cin)
- Emits a one-clock carry pulse on every terminal wrap.
- Instances chain via cy -> cin to build the clock's second/minute/hour/countdown chains.

---
 rtl/timer_gen.sv | 88 ++++++++
 tb/tb_timer_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_gen.sv
// Cyclic REL..CYCLE-1 timer with up/down, one-shot, runtime load and cascade tick (cin/cy).
// Optional input prescaler is compiled in with `define TIMER_GEN_PRESCALE_EN.
module timer_gen #(
  parameter int WIDTH     = 32,
  parameter int CYCLE     = 100,
  parameter int REL       = 5,
  parameter int PRESC_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cin,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic             cy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LO = WIDTH'(REL);
  localparam logic [WIDTH-1:0] HI = WIDTH'(CYCLE - 1);

  if (REL < 0 || REL >= CYCLE || 64'(CYCLE) > (64'd1 << WIDTH)) begin : g_bad_range
    $error("timer_gen: need 0 <= REL < CYCLE <= 2**WIDTH");
  end
  if (PRESC_DIV < 1 || PRESC_DIV > 65536) begin : g_bad_presc
    $error("timer_gen: PRESC_DIV must be in 1..65536");
  end

  logic ptick;

`ifdef TIMER_GEN_PRESCALE_EN
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc;

  // Counts qualified clocks independently of load and done; only reset clears it.
  assign ptick = (presc == PLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (en && cin) begin
      presc <= ptick ? '0 : presc + 1'b1;
    end
  end
`else
  assign ptick = 1'b1;
`endif

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step;
  logic             tick;

  assign term  = dir ? LO : HI;
  assign start = dir ? HI : LO;
  assign step  = dir ? (cnt - 1'b1) : (cnt + 1'b1);
  // A completed one-shot swallows ticks until the next load.
  assign tick  = en & cin & ptick & ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= LO;
      cy   <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      cy   <= 1'b0;
      done <= 1'b0;
    end else if (tick && (cnt == term)) begin
      cnt <= start;
      cy  <= 1'b1;
      if (mode) begin
        done <= 1'b1;
      end
    end else if (tick) begin
      cnt <= step;
      cy  <= 1'b0;
    end else begin
      cy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_gen.sv
// Directed bench for timer_gen: baseline wrap, one-shot down, load collision,
// cascade/enable, out-of-range load, async reset and (when compiled in) the prescaler.
module tb_timer_gen;

  logic        clk = 1'b0;
  logic        rst;

  logic        en, cin, load, mode, dir;
  logic [31:0] load_val;
  logic [31:0] cnt_m;
  logic        cy_m, done_m;

  logic        en_a, cin_a, load_a;
  logic [7:0]  load_val_a;
  logic [7:0]  cnt_a, cnt_b;
  logic        cy_a, cy_b, done_a, done_b;

  logic [31:0] cnt_p;
  logic        cy_p, done_p;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  timer_gen #(.WIDTH(32), .CYCLE(100), .REL(5)) u_main (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .load(load), .load_val(load_val),
    .mode(mode), .dir(dir), .cnt(cnt_m), .cy(cy_m), .done(done_m)
  );

  timer_gen #(.WIDTH(8), .CYCLE(60), .REL(0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .cin(cin_a), .load(load_a), .load_val(load_val_a),
    .mode(1'b0), .dir(1'b0), .cnt(cnt_a), .cy(cy_a), .done(done_a)
  );

  timer_gen #(.WIDTH(8), .CYCLE(60), .REL(0)) u_b (
    .clk(clk), .rst(rst), .en(1'b1), .cin(cy_a), .load(1'b0), .load_val(8'd0),
    .mode(1'b0), .dir(1'b0), .cnt(cnt_b), .cy(cy_b), .done(done_b)
  );

  timer_gen #(.WIDTH(32), .CYCLE(100), .REL(5), .PRESC_DIV(4)) u_p (
    .clk(clk), .rst(rst), .en(1'b1), .cin(1'b1), .load(1'b0), .load_val(32'd0),
    .mode(1'b0), .dir(1'b0), .cnt(cnt_p), .cy(cy_p), .done(done_p)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first_cy, second_cy, ncy;

    rst = 1'b0; en = 1'b1; cin = 1'b1; load = 1'b0; load_val = '0; mode = 1'b0; dir = 1'b0;
    en_a = 1'b0; cin_a = 1'b0; load_a = 1'b0; load_val_a = '0;

    #100;
    check("reset_cnt", 64'(cnt_m), 64'd5);
    check("reset_cy", 64'(cy_m), 64'd0);
    check("reset_done", 64'(done_m), 64'd0);
    check("reset_cnt_a", 64'(cnt_a), 64'd0);
    #3900;
    rst = 1'b1;

    // Up, auto-reload: cy on the 95th and 190th tick.
    first_cy = -1; second_cy = -1; ncy = 0;
    for (int k = 1; k <= 190; k++) begin
      @(posedge clk);
      #1;
      if (cy_m) begin
        ncy++;
        if (first_cy < 0) first_cy = k;
        else if (second_cy < 0) second_cy = k;
      end
      if (k == 1)  check("base_first_step", 64'(cnt_m), 64'd6);
      if (k == 94) check("base_top", 64'(cnt_m), 64'd99);
      if (k == 95) check("base_wrap_cnt", 64'(cnt_m), 64'd5);
      if (k == 96) check("base_after_wrap", 64'(cnt_m), 64'd6);
    end
    check("base_first_cy", 64'(first_cy), 64'd95);
    check("base_second_cy", 64'(second_cy), 64'd190);
    check("base_cy_count", 64'(ncy), 64'd2);

    // One-shot down from 10.
    dir = 1'b1; mode = 1'b1; load = 1'b1; load_val = 32'd10;
    step(1);
    check("os_load_cnt", 64'(cnt_m), 64'd10);
    load = 1'b0;
    step(5);
    check("os_at_rel", 64'(cnt_m), 64'd5);
    check("os_no_cy_yet", 64'(cy_m), 64'd0);
    step(1);
    check("os_wrap_cnt", 64'(cnt_m), 64'd99);
    check("os_wrap_cy", 64'(cy_m), 64'd1);
    check("os_done", 64'(done_m), 64'd1);
    ncy = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (cy_m) ncy++;
    end
    check("os_hold_cnt", 64'(cnt_m), 64'd99);
    check("os_hold_no_cy", 64'(ncy), 64'd0);
    mode = 1'b0;
    step(1);
    check("os_done_sticky", 64'(done_m), 64'd1);
    load = 1'b1; load_val = 32'd20;
    step(1);
    check("os_reload_cnt", 64'(cnt_m), 64'd20);
    check("os_reload_done", 64'(done_m), 64'd0);
    load = 1'b0;
    step(1);
    check("os_restart", 64'(cnt_m), 64'd19);

    // Load colliding with a terminal tick.
    dir = 1'b0; load = 1'b1; load_val = 32'd98;
    step(1);
    load = 1'b0;
    step(1);
    check("col_at_top", 64'(cnt_m), 64'd99);
    load = 1'b1; load_val = 32'd50;
    step(1);
    check("col_cnt", 64'(cnt_m), 64'd50);
    check("col_cy", 64'(cy_m), 64'd0);
    load = 1'b0;
    step(1);
    check("col_next", 64'(cnt_m), 64'd51);
    check("col_next_cy", 64'(cy_m), 64'd0);
    dir = 1'b1;
    step(1);
    check("dir_change_cnt", 64'(cnt_m), 64'd50);
    check("dir_change_cy", 64'(cy_m), 64'd0);
    dir = 1'b0;

    // Cascade A.cy -> B.cin, both 0..59.
    en_a = 1'b1; cin_a = 1'b1;
    for (int k = 1; k <= 121; k++) begin
      @(posedge clk);
      #1;
      if (k == 59)  check("casc_a_top", 64'(cnt_a), 64'd59);
      if (k == 60)  check("casc_a_cy", 64'(cy_a), 64'd1);
      if (k == 60)  check("casc_a_wrap", 64'(cnt_a), 64'd0);
      if (k == 60)  check("casc_b_before", 64'(cnt_b), 64'd0);
      if (k == 61)  check("casc_b_one", 64'(cnt_b), 64'd1);
      if (k == 121) check("casc_b_two", 64'(cnt_b), 64'd2);
      if (k == 121) check("casc_a_end", 64'(cnt_a), 64'd1);
    end
    en_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cin_a = ~cin_a;
      step(1);
    end
    check("en_low_drops_cin", 64'(cnt_a), 64'd1);

    // Out-of-range load wraps modulo 2^8 before reaching the terminal.
    en_a = 1'b1; cin_a = 1'b1; load_a = 1'b1; load_val_a = 8'd250;
    step(1);
    check("oor_load", 64'(cnt_a), 64'd250);
    load_a = 1'b0;
    step(6);
    check("oor_wrap_cnt", 64'(cnt_a), 64'd0);
    check("oor_wrap_no_cy", 64'(cy_a), 64'd0);
    step(1);
    check("oor_continue", 64'(cnt_a), 64'd1);
    en_a = 1'b0;

    // Async reset between edges.
    load = 1'b1; load_val = 32'd40;
    step(1);
    load = 1'b0;
    step(2);
    check("rst_pre_cnt", 64'(cnt_m), 64'd42);
    #5;
    rst = 1'b0;
    #1;
    check("rst_async_cnt", 64'(cnt_m), 64'd5);
    check("rst_async_cy", 64'(cy_m), 64'd0);
    check("rst_async_done", 64'(done_m), 64'd0);
    #20;
    rst = 1'b1;

`ifdef TIMER_GEN_PRESCALE_EN
    for (int k = 1; k <= 380; k++) begin
      @(posedge clk);
      #1;
      if (k == 3)   check("presc_hold", 64'(cnt_p), 64'd5);
      if (k == 4)   check("presc_first", 64'(cnt_p), 64'd6);
      if (k == 379) check("presc_top", 64'(cnt_p), 64'd99);
      if (k == 379) check("presc_no_cy", 64'(cy_p), 64'd0);
      if (k == 380) check("presc_wrap_cnt", 64'(cnt_p), 64'd5);
      if (k == 380) check("presc_wrap_cy", 64'(cy_p), 64'd1);
    end
`else
    step(4);
    check("nopresc_runs", 64'(cnt_p), 64'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
